write_iq: RTL and testbench

Output-side byte serializer for the FM radio datapath. Pops one 32-bit fixed-point I sample and one Q sample per transfer from two show-ahead FIFOs and dequantizes each to a signed 16-bit value. It then writes the pair to a byte FIFO as four little-endian bytes in the order I low, I high, Q low, Q high. It is the egress counterpart of the byte-stream IQ reader at the front of the chain and produces the same file format.

---
 rtl/fm_radio_pkg.sv | 24 ++
 rtl/dequant_sat.sv | 31 +++
 rtl/write_iq.sv | 101 ++++++++++
 tb/tb_write_iq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_radio_pkg.sv
// Shared FM radio datapath definitions: FSM encodings, default widths and the
// fixed-point dequantize rule used on the egress side.
package fm_radio_pkg;

    localparam int unsigned DEF_DATA_SIZE = 32;
    localparam int unsigned DEF_CHAR_SIZE = 16;
    localparam int unsigned DEF_BITS      = 10;

    typedef logic [2:0] state_t;

    localparam state_t READ         = 3'd0;
    localparam state_t WRITE_I_LOW  = 3'd1;
    localparam state_t WRITE_I_HIGH = 3'd2;
    localparam state_t WRITE_Q_LOW  = 3'd3;
    localparam state_t WRITE_Q_HIGH = 3'd4;

    // Arithmetic shift: truncates toward negative infinity.
    function automatic logic signed [DEF_DATA_SIZE-1:0] DEQUANTIZE(
        input logic signed [DEF_DATA_SIZE-1:0] v
    );
        return v >>> DEF_BITS;
    endfunction

endpackage

// File: rtl/dequant_sat.sv
// Combinational dequantize of one fixed-point sample to CHAR_SIZE bits.
// Define SATURATE_EN to clamp out-of-range values instead of wrapping them.
module dequant_sat
    import fm_radio_pkg::*;
(
    input  logic [DEF_DATA_SIZE-1:0] data_in,
    output logic [DEF_CHAR_SIZE-1:0] data_out
);

`ifdef SATURATE_EN
    localparam logic signed [DEF_DATA_SIZE-1:0] MAX_VAL =
        DEF_DATA_SIZE'(2 ** (DEF_CHAR_SIZE - 1) - 1);
    localparam logic signed [DEF_DATA_SIZE-1:0] MIN_VAL = -MAX_VAL - 1;

    logic signed [DEF_DATA_SIZE-1:0] shifted;

    always_comb begin
        shifted = DEQUANTIZE(data_in);
        if (shifted > MAX_VAL) begin
            data_out = {1'b0, {(DEF_CHAR_SIZE - 1){1'b1}}};
        end else if (shifted < MIN_VAL) begin
            data_out = {1'b1, {(DEF_CHAR_SIZE - 1){1'b0}}};
        end else begin
            data_out = shifted[DEF_CHAR_SIZE-1:0];
        end
    end
`else
    assign data_out = DEF_CHAR_SIZE'(DEQUANTIZE(data_in));
`endif

endmodule

// File: rtl/write_iq.sv
// Egress IQ serializer: pops an I/Q pair, dequantizes both and writes them as
// four little-endian bytes (I low, I high, Q low, Q high). Honors SATURATE_EN.
module write_iq
    import fm_radio_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned BYTE_SIZE = 8,
    parameter int unsigned CHAR_SIZE = DEF_CHAR_SIZE,
    parameter int unsigned BITS      = DEF_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] i_in,
    input  logic [DATA_SIZE-1:0] q_in,
    input  logic                 i_empty,
    input  logic                 q_empty,
    output logic                 in_rd_en,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [BYTE_SIZE-1:0] data_out
);

    state_t                 state_q, state_d;
    logic [CHAR_SIZE-1:0]   i_sample_q, q_sample_q;
    logic [CHAR_SIZE-1:0]   i_deq, q_deq;

    dequant_sat u_deq_i (
        .data_in  (i_in),
        .data_out (i_deq)
    );

    dequant_sat u_deq_q (
        .data_in  (q_in),
        .data_out (q_deq)
    );

    // Outputs are gated by reset so they drop the moment reset asserts.
    always_comb begin
        state_d   = state_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        data_out  = '0;
        unique case (state_q)
            READ: begin
                if (!i_empty && !q_empty) begin
                    in_rd_en = reset;
                    state_d  = WRITE_I_LOW;
                end
            end
            WRITE_I_LOW: begin
                data_out = i_sample_q[BYTE_SIZE-1:0];
                if (!out_full) begin
                    out_wr_en = reset;
                    state_d   = WRITE_I_HIGH;
                end
            end
            WRITE_I_HIGH: begin
                data_out = i_sample_q[2*BYTE_SIZE-1:BYTE_SIZE];
                if (!out_full) begin
                    out_wr_en = reset;
                    state_d   = WRITE_Q_LOW;
                end
            end
            WRITE_Q_LOW: begin
                data_out = q_sample_q[BYTE_SIZE-1:0];
                if (!out_full) begin
                    out_wr_en = reset;
                    state_d   = WRITE_Q_HIGH;
                end
            end
            WRITE_Q_HIGH: begin
                data_out = q_sample_q[2*BYTE_SIZE-1:BYTE_SIZE];
                if (!out_full) begin
                    out_wr_en = reset;
                    state_d   = READ;
                end
            end
            default: begin
                state_d = READ;
            end
        endcase
        if (!reset) begin
            data_out = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= READ;
            i_sample_q <= '0;
            q_sample_q <= '0;
        end else begin
            state_q <= state_d;
            if (in_rd_en) begin
                i_sample_q <= i_deq;
                q_sample_q <= q_deq;
            end
        end
    end

endmodule

// File: tb/tb_write_iq.sv
// Directed testbench for write_iq; expected bytes are hand-computed per configuration.
module tb_write_iq;

    logic        clock;
    logic        reset;
    logic [31:0] i_in;
    logic [31:0] q_in;
    logic        i_empty;
    logic        q_empty;
    logic        in_rd_en;
    logic        out_full;
    logic        out_wr_en;
    logic [7:0]  data_out;

    int checks;
    int failures;

    write_iq dut (
        .clock     (clock),
        .reset     (reset),
        .i_in      (i_in),
        .q_in      (q_in),
        .i_empty   (i_empty),
        .q_empty   (q_empty),
        .in_rd_en  (in_rd_en),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .data_out  (data_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic test_reset();
        reset    = 1'b0;
        i_in     = 32'h0048D000;
        q_in     = 32'hFFFFF800;
        i_empty  = 1'b0;
        q_empty  = 1'b0;
        out_full = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({in_rd_en, out_wr_en, data_out} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs: rd=%b wr=%b data=%h, required 0 0 00",
                     in_rd_en, out_wr_en, data_out);
        end
        i_empty = 1'b1;
        q_empty = 1'b1;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if ({in_rd_en, out_wr_en, data_out} !== 10'd0) begin
            failures++;
            $display("FAIL reset_idle: rd=%b wr=%b data=%h, required 0 0 00",
                     in_rd_en, out_wr_en, data_out);
        end
        @(posedge clock);
        #1;
    endtask

    // Entered just after a rising edge with the DUT in READ.
    task automatic test_pair(input string name, input logic [31:0] iv, input logic [31:0] qv,
                             input logic [31:0] exp_bytes);
        logic [7:0] exp_b;
        i_in     = iv;
        q_in     = qv;
        i_empty  = 1'b0;
        q_empty  = 1'b0;
        out_full = 1'b0;
        @(negedge clock);
        checks++;
        if (in_rd_en !== 1'b1 || out_wr_en !== 1'b0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL %s_pop: rd=%b wr=%b data=%h, required 1 0 00",
                     name, in_rd_en, out_wr_en, data_out);
        end
        @(posedge clock);
        #1;
        i_empty = 1'b1;
        q_empty = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_b = exp_bytes[31-8*k -: 8];
            @(negedge clock);
            checks++;
            if (out_wr_en !== 1'b1 || in_rd_en !== 1'b0 || data_out !== exp_b) begin
                failures++;
                $display("FAIL %s_byte%0d: wr=%b rd=%b data=%h, required 1 0 %h",
                         name, k, out_wr_en, in_rd_en, data_out, exp_b);
            end
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checks++;
        if ({in_rd_en, out_wr_en, data_out} !== 10'd0) begin
            failures++;
            $display("FAIL %s_back_to_read: rd=%b wr=%b data=%h, required 0 0 00",
                     name, in_rd_en, out_wr_en, data_out);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_backpressure();
        int cycles;
        logic [7:0] exp_seq [8];
        logic       exp_wr [8];
        logic       full_seq [8];
        exp_seq  = '{8'h00, 8'h34, 8'h12, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF};
        exp_wr   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        full_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        cycles = 0;
        i_in    = 32'h0048D000;
        q_in    = 32'hFFFFF800;
        i_empty = 1'b0;
        q_empty = 1'b0;
        for (int k = 0; k < 8; k++) begin
            out_full = full_seq[k];
            @(negedge clock);
            checks++;
            if (out_wr_en !== exp_wr[k] || data_out !== exp_seq[k] || in_rd_en !== (k == 0)) begin
                failures++;
                $display("FAIL bp_cycle%0d: rd=%b wr=%b data=%h, required %b %b %h",
                         k, in_rd_en, out_wr_en, data_out, (k == 0), exp_wr[k], exp_seq[k]);
            end
            @(posedge clock);
            #1;
            cycles++;
            if (k == 0) begin
                i_empty = 1'b1;
                q_empty = 1'b1;
            end
        end
        out_full = 1'b0;
        @(negedge clock);
        checks++;
        if (out_wr_en !== 1'b0 || data_out !== 8'h00 || cycles != 8) begin
            failures++;
            $display("FAIL bp_total: wr=%b data=%h cycles=%0d, required 0 00 8",
                     out_wr_en, data_out, cycles);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_unequal_fifos();
        int bad;
        bad     = 0;
        i_in    = 32'h0048D000;
        q_in    = 32'hFFFFF800;
        i_empty = 1'b0;
        q_empty = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (in_rd_en !== 1'b0 || out_wr_en !== 1'b0) bad++;
            @(posedge clock);
            #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL unequal_hold: bad_cycles=%0d, required 0", bad);
        end
        q_empty = 1'b0;
        @(negedge clock);
        checks++;
        if (in_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL unequal_pop: rd=%b, required 1", in_rd_en);
        end
        @(posedge clock);
        #1;
        i_empty = 1'b1;
        q_empty = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checks++;
        if (out_wr_en !== 1'b0 || in_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL unequal_single_pop: rd=%b wr=%b, required 0 0", in_rd_en, out_wr_en);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid_pair();
        logic [7:0] exp_seq [4];
        exp_seq  = '{8'hF0, 8'h2A, 8'h05, 8'h00};
        i_in     = 32'h0048D000;
        q_in     = 32'hFFFFF800;
        i_empty  = 1'b0;
        q_empty  = 1'b0;
        out_full = 1'b0;
        @(posedge clock);
        #1;
        i_empty = 1'b1;
        q_empty = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if (out_wr_en !== 1'b1 || data_out !== 8'h12) begin
            failures++;
            $display("FAIL rst_pre_i_high: wr=%b data=%h, required 1 12", out_wr_en, data_out);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({in_rd_en, out_wr_en, data_out} !== 10'd0) begin
            failures++;
            $display("FAIL rst_async: rd=%b wr=%b data=%h, required 0 0 00",
                     in_rd_en, out_wr_en, data_out);
        end
        i_in    = 32'h00ABC000;
        q_in    = 32'h00001400;
        i_empty = 1'b0;
        q_empty = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({in_rd_en, out_wr_en, data_out} !== 10'd0) begin
            failures++;
            $display("FAIL rst_held: rd=%b wr=%b data=%h, required 0 0 00",
                     in_rd_en, out_wr_en, data_out);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (in_rd_en !== 1'b1 || out_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_release_pop: rd=%b wr=%b, required 1 0", in_rd_en, out_wr_en);
        end
        @(posedge clock);
        #1;
        i_empty = 1'b1;
        q_empty = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (out_wr_en !== 1'b1 || data_out !== exp_seq[k]) begin
                failures++;
                $display("FAIL rst_next_byte%0d: wr=%b data=%h, required 1 %h",
                         k, out_wr_en, data_out, exp_seq[k]);
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pair("basic", 32'h0048D000, 32'hFFFFF800, 32'h3412FEFF);
`ifdef SATURATE_EN
        test_pair("pos_ovf", 32'h7FFFFFFF, 32'h00000000, 32'hFF7F0000);
        test_pair("neg_ovf", 32'h80000000, 32'hFFFFFFFF, 32'h0080FFFF);
`else
        test_pair("pos_ovf", 32'h7FFFFFFF, 32'h00000000, 32'hFFFF0000);
        test_pair("neg_ovf", 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF);
`endif
        test_pair("trunc", 32'hFFFFFC01, 32'h000007FF, 32'hFFFF0100);
        test_backpressure();
        test_unequal_fifos();
        test_reset_mid_pair();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
